// File: rtl/serial_compare_scheduler.sv
// serial_compare_scheduler
// Round-robin front end that shares one MSB-first bit-serial magnitude
// comparator among N_REQ word-oriented requesters. A granted operand pair is
// shifted through the comparator over WIDTH cycles, and a registered
// less/equal/greater result is returned, tagged with the requester index.

module serial_compare_scheduler #(
    parameter int WIDTH = 8,
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ID_W-1:0]        res_id,
    output logic                   res_less,
    output logic                   res_eq,
    output logic                   res_greater
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CMP_EQ = 2'd0,
        CMP_LT = 2'd1,
        CMP_GT = 2'd2
    } cmp_t;

    state_t           state;
    cmp_t             cmp;
    cmp_t             cmp_next;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [CNT_W-1:0] cnt;
    logic [ID_W-1:0]  cur_id;
    logic [ID_W-1:0]  last;

    logic [ID_W-1:0]  grant;
    logic             grant_found;
    logic [ID_W-1:0]  cand;
    logic [WIDTH-1:0] grant_a;
    logic [WIDTH-1:0] grant_b;
    logic             accept;
    logic             last_bit;

    // One step of the MSB-first comparator: the first differing bit decides,
    // after which the decision is absorbing.
    function automatic cmp_t cmp_step(input cmp_t c, input logic a, input logic b);
        cmp_t r;
        r = c;
        if (c == CMP_EQ) begin
            if (!a && b) begin
                r = CMP_LT;
            end else if (a && !b) begin
                r = CMP_GT;
            end
        end
        return r;
    endfunction

    // Round-robin search starting just after the last served requester,
    // wrapping explicitly so non-power-of-two N_REQ works too.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        cand        = last;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = (cand == ID_W'(N_REQ - 1)) ? '0 : cand + ID_W'(1);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant       = cand;
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        grant_a = '0;
        grant_b = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant == ID_W'(i)) begin
                grant_a = req_a[i*WIDTH +: WIDTH];
                grant_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Accept only in IDLE and never while reset is held.
    always_comb begin
        accept    = rst && (state == IDLE) && grant_found;
        req_ready = '0;
        if (accept) begin
            req_ready = {{(N_REQ-1){1'b0}}, 1'b1} << grant;
        end
    end

    // Comparator decision including the bit presented this cycle.
    always_comb begin
        cmp_next = cmp_step(cmp, sh_a[WIDTH-1], sh_b[WIDTH-1]);
        last_bit = (cnt == CNT_W'(WIDTH - 1));
    end

    // Control FSM with registered result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cmp         <= CMP_EQ;
            sh_a        <= '0;
            sh_b        <= '0;
            cnt         <= '0;
            cur_id      <= '0;
            last        <= ID_W'(N_REQ - 1);
            res_valid   <= 1'b0;
            res_id      <= '0;
            res_less    <= 1'b0;
            res_eq      <= 1'b0;
            res_greater <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sh_a   <= grant_a;
                        sh_b   <= grant_b;
                        cur_id <= grant;
                        last   <= grant;
                        cnt    <= '0;
                        cmp    <= CMP_EQ;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    cmp  <= cmp_next;
                    sh_a <= {sh_a[WIDTH-2:0], 1'b0};
                    sh_b <= {sh_b[WIDTH-2:0], 1'b0};
                    cnt  <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        res_valid   <= 1'b1;
                        res_id      <= cur_id;
                        res_less    <= (cmp_next == CMP_LT);
                        res_eq      <= (cmp_next == CMP_EQ);
                        res_greater <= (cmp_next == CMP_GT);
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_compare_scheduler.sv
// Directed self-checking bench for serial_compare_scheduler (WIDTH=8, N_REQ=4).

module tb_serial_compare_scheduler;

    localparam int WIDTH = 8;
    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic                   clk;
    logic                   rst;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ-1:0]       req_ready;
    logic                   res_valid;
    logic                   res_ready;
    logic [ID_W-1:0]        res_id;
    logic                   res_less;
    logic                   res_eq;
    logic                   res_greater;

    int errors = 0;
    int checks = 0;

    serial_compare_scheduler #(
        .WIDTH(WIDTH),
        .N_REQ(N_REQ),
        .ID_W (ID_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_less   (res_less),
        .res_eq     (res_eq),
        .res_greater(res_greater)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b);
        req_a[id*WIDTH +: WIDTH] = a;
        req_b[id*WIDTH +: WIDTH] = b;
    endtask

    // flags packed as {less, eq, greater}
    task automatic chk_result(input string tag, input logic [1:0] id, input logic [2:0] flags);
        chk({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
        chk({tag, "_id"}, {30'd0, res_id}, {30'd0, id});
        chk({tag, "_flags"}, {29'd0, res_less, res_eq, res_greater}, {29'd0, flags});
    endtask

    // One full transaction from a single valid requester with res_ready high.
    task automatic run_one(input string tag, input int id, input logic [7:0] a,
                           input logic [7:0] b, input logic [2:0] flags);
        set_req(id, a, b);
        req_valid = 4'b0001 << id;
        #1;
        chk({tag, "_ready"}, {28'd0, req_ready}, {28'd0, 4'b0001 << id});
        tick();
        req_valid = '0;
        #1;
        chk({tag, "_ready_shift"}, {28'd0, req_ready}, 32'd0);
        for (int i = 0; i < 7; i++) tick();
        chk({tag, "_early"}, {31'd0, res_valid}, 32'd0);
        tick();
        chk_result(tag, 2'(id), flags);
        tick();
        chk({tag, "_cleared"}, {31'd0, res_valid}, 32'd0);
    endtask

    logic [3:0] exp_grant [5];
    logic [2:0] exp_flags [5];
    int         gr_cyc    [5];
    int         ngr;
    int         nres;

    initial begin
        rst       = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;

        // Reset and idle
        tick();
        tick();
        chk("rst_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_res", {28'd0, res_valid, res_less, res_eq, res_greater}, 32'd0);
        chk("rst_id", {30'd0, res_id}, 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle", {27'd0, req_ready, res_valid}, 32'd0);
        end

        // Single compares
        run_one("gt_80_7f", 2, 8'h80, 8'h7F, 3'b001);
        run_one("eq_5a", 1, 8'h5A, 8'h5A, 3'b010);
        run_one("lsb_lt", 3, 8'h5A, 8'h5B, 3'b100);

        // Round-robin: last served is 3, so order is 0,1,2,3,0
        set_req(0, 8'h00, 8'h20);
        set_req(1, 8'h10, 8'h20);
        set_req(2, 8'h20, 8'h20);
        set_req(3, 8'h30, 8'h20);
        exp_grant[0] = 4'b0001; exp_flags[0] = 3'b100;
        exp_grant[1] = 4'b0010; exp_flags[1] = 3'b100;
        exp_grant[2] = 4'b0100; exp_flags[2] = 3'b010;
        exp_grant[3] = 4'b1000; exp_flags[3] = 3'b001;
        exp_grant[4] = 4'b0001; exp_flags[4] = 3'b100;
        req_valid = 4'b1111;
        #1;
        ngr  = 0;
        nres = 0;
        for (int c = 0; c < 60; c++) begin
            if (req_ready != '0 && ngr < 5) begin
                chk("rr_grant", {28'd0, req_ready}, {28'd0, exp_grant[ngr]});
                gr_cyc[ngr] = c;
                if (ngr > 0) chk("rr_gap", gr_cyc[ngr] - gr_cyc[ngr-1], 32'd10);
                ngr++;
            end
            if (res_valid && nres < 5) begin
                chk("rr_res_id", {30'd0, res_id}, {30'd0, 2'(nres % 4)});
                chk("rr_res_flags", {29'd0, res_less, res_eq, res_greater},
                    {29'd0, exp_flags[nres]});
                nres++;
            end
            tick();
            if (ngr == 5) req_valid = '0;
        end
        chk("rr_ngrants", ngr, 32'd5);
        chk("rr_nresults", nres, 32'd5);

        // Back-pressure: requester 1 result held while requester 0 waits
        run_one("pre_bp", 2, 8'h01, 8'h02, 3'b100);
        set_req(1, 8'h10, 8'h01);
        req_valid = 4'b0010;
        res_ready = 1'b0;
        #1;
        chk("bp_ready", {28'd0, req_ready}, 32'd2);
        tick();
        set_req(0, 8'h00, 8'hFF);
        req_valid = 4'b0001;
        for (int i = 0; i < 8; i++) tick();
        chk_result("bp_first", 2'd1, 3'b001);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_result("bp_hold", 2'd1, 3'b001);
            chk("bp_hold_ready", {28'd0, req_ready}, 32'd0);
        end
        res_ready = 1'b1;
        #1;
        chk("bp_release_ready", {28'd0, req_ready}, 32'd0);
        tick();
        chk("bp_back_idle", {31'd0, res_valid}, 32'd0);
        chk("bp_idle_grant", {28'd0, req_ready}, 32'd1);
        tick();
        req_valid = '0;
        #1;
        chk("bp_accepted", {28'd0, req_ready}, 32'd0);
        for (int i = 0; i < 7; i++) tick();
        chk("bp2_early", {31'd0, res_valid}, 32'd0);
        tick();
        chk_result("bp2", 2'd0, 3'b100);
        tick();

        // Mid-shift reset: requester 2 in flight, so without the arbitration
        // restart requester 3 would be next.
        set_req(2, 8'hFF, 8'h00);
        req_valid = 4'b0100;
        #1;
        chk("mr_ready", {28'd0, req_ready}, 32'd4);
        tick();
        set_req(0, 8'h33, 8'h33);
        set_req(3, 8'hFF, 8'hFF);
        req_valid = 4'b1001;
        tick();
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("mr_rst_out", {27'd0, req_ready, res_valid}, 32'd0);
        chk("mr_rst_flags", {29'd0, res_less, res_eq, res_greater}, 32'd0);
        tick();
        rst = 1'b1;
        #1;
        chk("mr_restart_grant", {28'd0, req_ready}, 32'd1);
        tick();
        req_valid = '0;
        for (int i = 0; i < 7; i++) tick();
        chk("mr_early", {31'd0, res_valid}, 32'd0);
        tick();
        chk_result("mr_after", 2'd0, 3'b010);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
